// File: rtl/alu_pkg.sv
// Shared ALU definitions: divider state encoding, datapath width, divide-by-zero quotient.
// No logic of its own; imported by the divider and its subtractor.
// Macro DIV_32_SIGNED_EN is consumed by div_32, not here.
package alu_pkg;

   localparam int ALU_WIDTH = 32;

   localparam logic [ALU_WIDTH-1:0] DIV_ZERO_QUOT = {ALU_WIDTH{1'b1}};

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } div_state_t;

endpackage

// File: rtl/sub_32.sv
// WIDTH-bit subtractor for the divider's restoring step: diff = x - y, borrow = x < y.
// Combinational, zero latency.
// No flow control; purely combinational.
module sub_32
   import alu_pkg::*;
#(
   parameter int WIDTH = ALU_WIDTH
) (
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   output logic [WIDTH-1:0] diff,
   output logic             borrow
);

   logic [WIDTH:0] full;

   // Zero-extend both sides so the extra top bit of the result is the borrow.
   assign full   = {1'b0, x} - {1'b0, y};
   assign diff   = full[WIDTH-1:0];
   assign borrow = full[WIDTH];

endmodule

// File: rtl/div_32.sv
// Iterative restoring divider, one quotient bit per clock; signed mode under DIV_32_SIGNED_EN.
// Latency: WIDTH+1 cycles from accept to o_valid (divisor zero: result on the accept edge).
// Backpressure: result held in DONE until i_ready; o_ready stays low until the result is taken.
module div_32
   import alu_pkg::*;
#(
   parameter int WIDTH = ALU_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_valid,
   output logic             o_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             i_signed,
   output logic             o_valid,
   input  logic             i_ready,
   output logic [WIDTH-1:0] o_quot,
   output logic [WIDTH-1:0] o_rem,
   output logic             o_div_zero,
   output logic             overflow
);

   localparam int CNT_W = $clog2(WIDTH);
   localparam logic [WIDTH-1:0] ZERO_QUOT = {WIDTH{1'b1}};

   div_state_t       state;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] dvd;
   logic [WIDTH-1:0] dsr;
   logic [WIDTH-1:0] rem;
   logic             neg_q;
   logic             neg_r;
   logic             ovf_r;

   logic             signed_mode;
   logic             ovf_case;
   logic [WIDTH-1:0] a_mag;
   logic [WIDTH-1:0] b_mag;
   logic [WIDTH-1:0] rem_next;
   logic [WIDTH-1:0] diff;
   logic             borrow;

`ifdef DIV_32_SIGNED_EN
   localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

   assign signed_mode = i_signed;
   // Most-negative / -1 overflows; the datapath already yields MIN_NEG, rem 0, so only flag it.
   assign ovf_case    = signed_mode && (a == MIN_NEG) && (b == {WIDTH{1'b1}});
`else
   logic unused_signed;

   assign unused_signed = i_signed;
   assign signed_mode   = 1'b0;
   assign ovf_case      = 1'b0;
`endif

   assign a_mag = (signed_mode && a[WIDTH-1]) ? -a : a;
   assign b_mag = (signed_mode && b[WIDTH-1]) ? -b : b;

   // The dividend register shifts out its MSB into the remainder and takes quotient bits in at the LSB.
   assign rem_next = {rem[WIDTH-2:0], dvd[WIDTH-1]};

   sub_32 #(
      .WIDTH (WIDTH)
   ) u_sub (
      .x      (rem_next),
      .y      (dsr),
      .diff   (diff),
      .borrow (borrow)
   );

   assign o_ready = (state == IDLE);
   assign o_valid = (state == DONE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         cnt        <= '0;
         dvd        <= '0;
         dsr        <= '0;
         rem        <= '0;
         neg_q      <= 1'b0;
         neg_r      <= 1'b0;
         ovf_r      <= 1'b0;
         o_quot     <= '0;
         o_rem      <= '0;
         o_div_zero <= 1'b0;
         overflow   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (i_valid) begin
                  dvd   <= a_mag;
                  dsr   <= b_mag;
                  rem   <= '0;
                  cnt   <= '0;
                  neg_q <= signed_mode && (a[WIDTH-1] ^ b[WIDTH-1]);
                  neg_r <= signed_mode && a[WIDTH-1];
                  ovf_r <= ovf_case;
                  if (b == '0) begin
                     o_quot     <= ZERO_QUOT;
                     o_rem      <= a;
                     o_div_zero <= 1'b1;
                     overflow   <= 1'b0;
                     state      <= DONE;
                  end else begin
                     state <= CALC;
                  end
               end
            end
            CALC: begin
               dvd <= {dvd[WIDTH-2:0], ~borrow};
               rem <= borrow ? rem_next : diff;
               cnt <= cnt + CNT_W'(1);
               if (cnt == CNT_W'(WIDTH - 1)) begin
                  state <= FIX;
               end
            end
            FIX: begin
               o_quot     <= neg_q ? -dvd : dvd;
               o_rem      <= neg_r ? -rem : rem;
               o_div_zero <= 1'b0;
               overflow   <= ovf_r;
               state      <= DONE;
            end
            DONE: begin
               if (i_ready) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_div_32.sv
// Directed bench for div_32: arithmetic model plus per-cycle result compare, with literal pins.
module tb_div_32;
   import alu_pkg::*;

   localparam int W = ALU_WIDTH;

   typedef struct packed {
      logic [W-1:0] q;
      logic [W-1:0] r;
      logic         dz;
      logic         ov;
   } res_t;

`ifdef DIV_32_SIGNED_EN
   localparam logic [W-1:0] NEG7_Q = 32'hFFFF_FFFD;
   localparam logic [W-1:0] NEG7_R = 32'hFFFF_FFFF;
   localparam logic [W-1:0] OVF_Q  = 32'h8000_0000;
   localparam logic [W-1:0] OVF_R  = 32'h0000_0000;
   localparam logic [W-1:0] OVF_F  = 32'd1;
`else
   localparam logic [W-1:0] NEG7_Q = 32'h7FFF_FFFC;
   localparam logic [W-1:0] NEG7_R = 32'h0000_0001;
   localparam logic [W-1:0] OVF_Q  = 32'h0000_0000;
   localparam logic [W-1:0] OVF_R  = 32'h8000_0000;
   localparam logic [W-1:0] OVF_F  = 32'd0;
`endif

   logic         clk      = 1'b0;
   logic         rst_n    = 1'b0;
   logic         i_valid  = 1'b0;
   logic         i_ready  = 1'b0;
   logic         i_signed = 1'b0;
   logic [W-1:0] a        = '0;
   logic [W-1:0] b        = '0;
   logic         o_ready;
   logic         o_valid;
   logic         o_div_zero;
   logic         overflow;
   logic [W-1:0] o_quot;
   logic [W-1:0] o_rem;

   int   n_tests = 0;
   int   n_fail  = 0;
   res_t exp_q[$];

   always #5 clk = ~clk;

   div_32 #(.WIDTH(W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_valid    (i_valid),
      .o_ready    (o_ready),
      .a          (a),
      .b          (b),
      .i_signed   (i_signed),
      .o_valid    (o_valid),
      .i_ready    (i_ready),
      .o_quot     (o_quot),
      .o_rem      (o_rem),
      .o_div_zero (o_div_zero),
      .overflow   (overflow)
   );

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] expv);
      n_tests++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, expv);
      end
   endtask

   // What the divider must return, from plain integer arithmetic.
   function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic sgn);
      res_t r;
      logic s;
`ifdef DIV_32_SIGNED_EN
      s = sgn;
`else
      s = sgn && 1'b0;
`endif
      r.dz = (y == '0);
      r.ov = 1'b0;
      if (y == '0) begin
         r.q = DIV_ZERO_QUOT;
         r.r = x;
      end else if (s && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
         r.q  = 32'h8000_0000;
         r.r  = '0;
         r.ov = 1'b1;
      end else if (s) begin
         r.q = $signed(x) / $signed(y);
         r.r = $signed(x) % $signed(y);
      end else begin
         r.q = x / y;
         r.r = x % y;
      end
      return r;
   endfunction

   // Every cycle a result is presented, it must match the oldest outstanding request.
   always @(negedge clk) begin
      if (rst_n && o_valid) begin
         check("pending_result", W'(exp_q.size() != 0), W'(1));
         if (exp_q.size() != 0) begin
            check("mon_quot", o_quot, exp_q[0].q);
            check("mon_rem", o_rem, exp_q[0].r);
            check("mon_div_zero", W'(o_div_zero), W'(exp_q[0].dz));
            check("mon_overflow", W'(overflow), W'(exp_q[0].ov));
            if (i_ready) void'(exp_q.pop_front());
         end
      end
   end

   // hold < 0: i_ready high before the result arrives; otherwise stall hold cycles, optionally
   // presenting a competing request while stalled.
   task automatic run(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                      input logic s, input int hold, input bit probe, output res_t got);
      int lat;
      int t;
      t = 0;
      while (!o_ready && t < 200) begin
         @(posedge clk); #1;
         t++;
      end
      check({tag, "_ready_wait"}, W'(o_ready), W'(1));
      a        = x;
      b        = y;
      i_signed = s;
      i_valid  = 1'b1;
      i_ready  = (hold < 0);
      exp_q.push_back(model(x, y, s));
      @(posedge clk); #1;
      i_valid  = 1'b0;
      a        = $urandom;
      b        = $urandom;
      i_signed = 1'($urandom_range(0, 1));
      check({tag, "_busy"}, W'(o_ready), W'(0));
      lat = 0;
      while (!o_valid && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
      if (y == '0) check({tag, "_dz_latency_late"}, W'(lat > 1), W'(0));
      else         check({tag, "_latency"}, W'(lat), W'(W + 1));
      got = {o_quot, o_rem, o_div_zero, overflow};
      if (hold < 0) begin
         @(posedge clk); #1;
         check({tag, "_valid_one_cycle"}, W'(o_valid), W'(0));
         check({tag, "_ready_after"}, W'(o_ready), W'(1));
         i_ready = 1'b0;
      end else begin
         for (int k = 0; k < hold; k++) begin
            if (probe) begin
               i_valid = 1'b1;
               a       = 32'd5;
               b       = 32'd1;
            end
            @(posedge clk); #1;
            check({tag, "_hold_valid"}, W'(o_valid), W'(1));
            check({tag, "_hold_ready"}, W'(o_ready), W'(0));
            check({tag, "_hold_quot"}, o_quot, got.q);
            check({tag, "_hold_rem"}, o_rem, got.r);
         end
         i_valid = 1'b0;
         i_ready = 1'b1;
         @(posedge clk); #1;
         check({tag, "_ready_after"}, W'(o_ready), W'(1));
         check({tag, "_valid_after"}, W'(o_valid), W'(0));
         i_ready = 1'b0;
      end
   endtask

   initial begin
      res_t got;
      logic [W-1:0] va[8];
      logic [W-1:0] vb[8];
      logic         vs[8];

      #500000;
      $display("FAIL global_timeout: simulation did not finish, %0d checks so far", n_tests);
      $fatal(1, "timeout");
   end

   initial begin
      res_t got;
      logic [W-1:0] va[8];
      logic [W-1:0] vb[8];
      logic         vs[8];
      va = '{32'd7, 32'hFFFF_FFF9, 32'd0, 32'd5, 32'hFFFF_FF00, 32'hDEAD_BEEF, 32'h8000_0000, 32'h8000_0001};
      vb = '{32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'd5, 32'd10, 32'd0, 32'h0000_1234, 32'hFFFF_FFFF, 32'd3};
      vs = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

      repeat (2) @(posedge clk);
      #1;
      check("rst_ready", W'(o_ready), W'(1));
      check("rst_valid", W'(o_valid), W'(0));
      check("rst_quot", o_quot, '0);
      check("rst_rem", o_rem, '0);
      check("rst_div_zero", W'(o_div_zero), W'(0));
      check("rst_overflow", W'(overflow), W'(0));
      rst_n = 1'b1;
      @(posedge clk); #1;

      run("u100_7", 32'd100, 32'd7, 1'b0, 0, 1'b0, got);
      check("u100_7_q", got.q, 32'd14);
      check("u100_7_r", got.r, 32'd2);
      check("u100_7_flags", W'({got.dz, got.ov}), W'(0));

      run("dz", 32'h1234_5678, 32'd0, 1'b0, 0, 1'b0, got);
      check("dz_q", got.q, 32'hFFFF_FFFF);
      check("dz_r", got.r, 32'h1234_5678);
      check("dz_flag", W'(got.dz), W'(1));

      run("neg7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, 0, 1'b0, got);
      check("neg7_2_q", got.q, NEG7_Q);
      check("neg7_2_r", got.r, NEG7_R);
      check("neg7_2_ov", W'(got.ov), W'(0));

      run("ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0, 1'b0, got);
      check("ovf_q", got.q, OVF_Q);
      check("ovf_r", got.r, OVF_R);
      check("ovf_flag", W'(got.ov), OVF_F);

      run("bp", 32'd1000, 32'd33, 1'b0, 10, 1'b1, got);
      check("bp_q", got.q, 32'd30);
      check("bp_r", got.r, 32'd10);
      check("bp_no_extra", W'(exp_q.size()), W'(0));

      run("rdy_hi", 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, -1, 1'b0, got);
      check("rdy_hi_q", got.q, 32'd1);
      check("rdy_hi_r", got.r, 32'd1);

      // Abort a division ten cycles into the iteration.
      a       = 32'd1000;
      b       = 32'd3;
      i_valid = 1'b1;
      @(posedge clk); #1;
      i_valid = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      exp_q.delete();
      check("abort_ready", W'(o_ready), W'(1));
      check("abort_valid", W'(o_valid), W'(0));
      check("abort_quot", o_quot, '0);
      check("abort_rem", o_rem, '0);
      check("abort_flags", W'({o_div_zero, overflow}), W'(0));
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      run("post_rst", 32'hFFFF_FFFF, 32'd1, 1'b0, 0, 1'b0, got);
      check("post_rst_q", got.q, 32'hFFFF_FFFF);
      check("post_rst_r", got.r, 32'd0);

      for (int i = 0; i < 8; i++) begin
         run($sformatf("vec%0d", i), va[i], vb[i], vs[i], i % 3, 1'b0, got);
      end

      repeat (3) @(posedge clk);
      check("queue_drained", W'(exp_q.size()), W'(0));
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
